wb_sequencer: RTL and testbench

Writeback sequencer for the datapath's 32-bit writeback path. It accepts one writeback request at a time, either an ALU result or a load. For a load it runs the data-memory read handshake with a timeout. It then drives the memory/result mux select (`mMemSel`) and issues a single register-file write strobe. It sits between the execute stage and the `Mux2_1_32` writeback mux / register file.

---
 rtl/wb_sequencer.sv | 116 +++++++++++
 tb/tb_wb_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/wb_sequencer.sv
// Writeback sequencer: accepts one ALU/load request, runs the load handshake
// with a timeout, then drives the writeback mux select and a single RF write.
module wb_sequencer #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issueValid,
  output logic              issueReady,
  input  logic              issueLoad,
  input  logic [ADDR_W-1:0] issueRd,
  input  logic [DATA_W-1:0] issueRes,
  output logic              memReq,
  input  logic              memReady,
  output logic              mMemSel,
  output logic [DATA_W-1:0] resOut,
  output logic              rfWe,
  output logic [ADDR_W-1:0] rfWaddr,
  output logic              memErr
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, MEM_WAIT, WRITE} state_t;

  state_t              state, stateNext;
  logic [CNT_W-1:0]    cnt, cntNext;
  logic                loadQ, loadNext;
  logic [ADDR_W-1:0]   rdQ, rdNext;
  logic [DATA_W-1:0]   resQ, resNext;
  logic                memReqNext, mMemSelNext, rfWeNext, memErrNext;

  assign issueReady = (state == IDLE);
  assign resOut     = resQ;
  assign rfWaddr    = rdQ;

  // Registered outputs are computed from the transition being taken, so they
  // line up with the state they belong to rather than lagging by one cycle.
  always_comb begin
    stateNext   = state;
    cntNext     = cnt;
    loadNext    = loadQ;
    rdNext      = rdQ;
    resNext     = resQ;
    memReqNext  = 1'b0;
    mMemSelNext = 1'b0;
    rfWeNext    = 1'b0;
    memErrNext  = 1'b0;
    case (state)
      IDLE: begin
        if (issueValid) begin
          loadNext = issueLoad;
          rdNext   = issueRd;
          resNext  = issueRes;
          cntNext  = '0;
          if (issueLoad) begin
            stateNext   = MEM_WAIT;
            memReqNext  = 1'b1;
            mMemSelNext = 1'b1;
          end else begin
            stateNext = WRITE;
            rfWeNext  = (issueRd != '0);
          end
        end
      end
      MEM_WAIT: begin
        cntNext     = cnt + CNT_W'(1);
        memReqNext  = 1'b1;
        mMemSelNext = 1'b1;
        // memReady takes priority over a coincident timeout
        if (memReady) begin
          stateNext = WRITE;
          rfWeNext  = (rdQ != '0);
        end else if (cnt + CNT_W'(1) == CNT_W'(MEM_TIMEOUT)) begin
          stateNext   = IDLE;
          memReqNext  = 1'b0;
          mMemSelNext = 1'b0;
          memErrNext  = 1'b1;
        end
      end
      WRITE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      loadQ   <= 1'b0;
      rdQ     <= '0;
      resQ    <= '0;
      memReq  <= 1'b0;
      mMemSel <= 1'b0;
      rfWe    <= 1'b0;
      memErr  <= 1'b0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      loadQ   <= loadNext;
      rdQ     <= rdNext;
      resQ    <= resNext;
      memReq  <= memReqNext;
      mMemSel <= mMemSelNext;
      rfWe    <= rfWeNext;
      memErr  <= memErrNext;
    end
  end

endmodule

// File: tb/tb_wb_sequencer.sv
// Directed bench for wb_sequencer: ALU writes, loads, timeout, r0 suppression
// and asynchronous reset during a load.
module tb_wb_sequencer;

  localparam int DATA_W      = 32;
  localparam int ADDR_W      = 5;
  localparam int MEM_TIMEOUT = 15;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              issueValid;
  logic              issueReady;
  logic              issueLoad;
  logic [ADDR_W-1:0] issueRd;
  logic [DATA_W-1:0] issueRes;
  logic              memReq;
  logic              memReady;
  logic              mMemSel;
  logic [DATA_W-1:0] resOut;
  logic              rfWe;
  logic [ADDR_W-1:0] rfWaddr;
  logic              memErr;

  int unsigned assertCnt = 0;
  int unsigned failCnt   = 0;
  int unsigned seen;

  wb_sequencer #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W),
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .issueValid(issueValid),
    .issueReady(issueReady),
    .issueLoad(issueLoad),
    .issueRd(issueRd),
    .issueRes(issueRes),
    .memReq(memReq),
    .memReady(memReady),
    .mMemSel(mMemSel),
    .resOut(resOut),
    .rfWe(rfWe),
    .rfWaddr(rfWaddr),
    .memErr(memErr)
  );

  always #5 clk = ~clk;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assertCnt++;
    if (actual !== expected) begin
      failCnt++;
      $display("FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled and inputs driven here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic load, input logic [ADDR_W-1:0] rd, input logic [DATA_W-1:0] res);
    issueValid = 1'b1;
    issueLoad  = load;
    issueRd    = rd;
    issueRes   = res;
  endtask

  initial begin
    rst_n      = 1'b0;
    issueValid = 1'b0;
    issueLoad  = 1'b0;
    issueRd    = '0;
    issueRes   = '0;
    memReady   = 1'b0;

    // Reset state
    tick();
    checkEq("rst_ready",  issueReady, 1);
    checkEq("rst_memReq", memReq, 0);
    checkEq("rst_sel",    mMemSel, 0);
    checkEq("rst_rfWe",   rfWe, 0);
    checkEq("rst_memErr", memErr, 0);
    checkEq("rst_resOut", resOut, 0);
    checkEq("rst_waddr",  rfWaddr, 0);
    rst_n = 1'b1;
    tick();

    // ALU write rd=5, res=400
    issue(1'b0, 5'd5, 32'd400);
    tick();
    issueValid = 1'b0;
    checkEq("alu_rfWe",  rfWe, 1);
    checkEq("alu_waddr", rfWaddr, 5);
    checkEq("alu_res",   resOut, 400);
    checkEq("alu_sel",   mMemSel, 0);
    checkEq("alu_ready", issueReady, 0);
    checkEq("alu_memReq", memReq, 0);
    tick();
    checkEq("alu_rfWe_off", rfWe, 0);
    checkEq("alu_ready2",   issueReady, 1);
    checkEq("alu_res_hold", resOut, 400);

    // Load rd=7, memReady sampled at the second edge after accept
    issue(1'b1, 5'd7, 32'd11);
    seen = 0;
    tick();
    issueValid = 1'b0;
    seen += memReq;
    checkEq("ld_sel0",  mMemSel, 1);
    checkEq("ld_rfWe0", rfWe, 0);
    tick();
    seen += memReq;
    checkEq("ld_rfWe1", rfWe, 0);
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    seen += memReq;
    checkEq("ld_rfWe",  rfWe, 1);
    checkEq("ld_waddr", rfWaddr, 7);
    checkEq("ld_sel",   mMemSel, 1);
    tick();
    seen += memReq;
    checkEq("ld_memReq_cycles", seen, 3);
    checkEq("ld_rfWe_off", rfWe, 0);
    checkEq("ld_sel_off",  mMemSel, 0);
    checkEq("ld_ready",    issueReady, 1);

    // Timeout: memReady never asserted; ALU request held waiting
    issue(1'b1, 5'd9, 32'd0);
    tick();
    issueValid = 1'b0;
    seen = 0;
    for (int j = 1; j < MEM_TIMEOUT; j++) begin
      if (j == MEM_TIMEOUT - 1) issue(1'b0, 5'd3, 32'd77);
      tick();
      seen += memErr + rfWe + (memReq ? 0 : 1);
    end
    checkEq("to_early_activity", seen, 0);
    tick();
    checkEq("to_memErr",  memErr, 1);
    checkEq("to_memReq",  memReq, 0);
    checkEq("to_rfWe",    rfWe, 0);
    checkEq("to_ready",   issueReady, 1);
    tick();
    issueValid = 1'b0;
    checkEq("to_memErr_off", memErr, 0);
    checkEq("to_next_rfWe",  rfWe, 1);
    checkEq("to_next_waddr", rfWaddr, 3);
    checkEq("to_next_res",   resOut, 77);
    tick();

    // memReady on the last allowed MEM_WAIT cycle
    issue(1'b1, 5'd4, 32'd0);
    tick();
    issueValid = 1'b0;
    for (int j = 1; j < MEM_TIMEOUT; j++) tick();
    memReady = 1'b1;
    tick();
    memReady = 1'b0;
    checkEq("late_memErr", memErr, 0);
    checkEq("late_rfWe",   rfWe, 1);
    checkEq("late_waddr",  rfWaddr, 4);
    checkEq("late_sel",    mMemSel, 1);
    tick();
    checkEq("late_memErr2", memErr, 0);
    checkEq("late_rfWe_off", rfWe, 0);

    // rd=0 suppresses the write; valid held through WRITE
    issue(1'b0, 5'd0, 32'd500);
    tick();
    checkEq("r0_rfWe",  rfWe, 0);
    checkEq("r0_res",   resOut, 500);
    checkEq("r0_ready", issueReady, 0);
    issue(1'b0, 5'd2, 32'd600);
    tick();
    checkEq("hold_rfWe",  rfWe, 0);
    checkEq("hold_res",   resOut, 500);
    checkEq("hold_ready", issueReady, 1);
    tick();
    issueValid = 1'b0;
    checkEq("hold2_rfWe",  rfWe, 1);
    checkEq("hold2_waddr", rfWaddr, 2);
    checkEq("hold2_res",   resOut, 600);
    tick();

    // Asynchronous reset during MEM_WAIT
    issue(1'b1, 5'd6, 32'd0);
    tick();
    issueValid = 1'b0;
    tick();
    checkEq("mid_memReq_pre", memReq, 1);
    #2;
    rst_n = 1'b0;
    #1;
    checkEq("mid_memReq", memReq, 0);
    checkEq("mid_ready",  issueReady, 1);
    tick();
    rst_n    = 1'b1;
    memReady = 1'b1;
    seen = 0;
    for (int j = 0; j < 4; j++) begin
      tick();
      seen += rfWe + memErr + memReq;
    end
    memReady = 1'b0;
    checkEq("mid_after_quiet", seen, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCnt, failCnt);
    $finish;
  end

endmodule
